// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: two read ports, one write-back port and a
// reservation port. The master drives indices/data, the slave returns read data and busy flags.
interface regfile_scoreboard_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    RA;
  logic [AW-1:0]    RB;
  logic [WIDTH-1:0] BusA;
  logic [WIDTH-1:0] BusB;
  logic             BusyA;
  logic             BusyB;
  logic [AW-1:0]    RW;
  logic [WIDTH-1:0] BusW;
  logic             RegWr;
  logic [AW-1:0]    RRsv;
  logic             RsvEn;
  logic             AnyBusy;

  modport master (
    output RA, RB, RW, BusW, RegWr, RRsv, RsvEn,
    input  BusA, BusB, BusyA, BusyB, AnyBusy
  );

  modport slave (
    input  RA, RB, RW, BusW, RegWr, RRsv, RsvEn,
    output BusA, BusB, BusyA, BusyB, AnyBusy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard: combinational reads with
// optional write-to-read forwarding and an optional hardwired zero register.
module regfile_scoreboard #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = DEPTH - 1,
  parameter int BYPASS   = 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  regfile_scoreboard_if.slave   bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam bit            ZERO_EN  = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
  localparam logic [AW-1:0] ZERO_IDX = ZERO_EN ? AW'(ZERO_REG) : '0;
  localparam bit            BYP_EN   = (BYPASS != 0);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic w_wr_ok;
  logic w_rsv_ok;
  logic w_fwd_a;
  logic w_fwd_b;
  logic w_rersv_a;
  logic w_rersv_b;

  function automatic logic is_zero(input logic [AW-1:0] idx);
    return ZERO_EN && (idx == ZERO_IDX);
  endfunction

  assign w_wr_ok   = bus.RegWr && !is_zero(bus.RW);
  assign w_rsv_ok  = bus.RsvEn && !is_zero(bus.RRsv);
  assign w_fwd_a   = BYP_EN && w_wr_ok && (bus.RW == bus.RA);
  assign w_fwd_b   = BYP_EN && w_wr_ok && (bus.RW == bus.RB);
  assign w_rersv_a = w_rsv_ok && (bus.RRsv == bus.RA);
  assign w_rersv_b = w_rsv_ok && (bus.RRsv == bus.RB);

  // NOTE: the storage array is reset explicitly because an architectural
  // read of any register after reset must return 0, not power-up garbage.
  // NOTE: sequential state uses non-blocking assignments so the later
  // reservation statement cleanly overrides the write-back clear below.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[bus.RW] <= bus.BusW;
        r_busy[bus.RW] <= 1'b0;
      end
      // A new producer reserving the same register takes priority over the write-back clear
      if (w_rsv_ok) begin
        r_busy[bus.RRsv] <= 1'b1;
      end
    end
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    bus.BusA  = r_regs[bus.RA];
    bus.BusyA = r_busy[bus.RA];
    if (w_fwd_a) begin
      bus.BusA = bus.BusW;
      if (!w_rersv_a) begin
        bus.BusyA = 1'b0;
      end
    end
    // Outputs are forced low while in reset so forwarded BusW cannot leak out
    if (is_zero(bus.RA) || !Reset_n) begin
      bus.BusA  = '0;
      bus.BusyA = 1'b0;
    end
  end

  always_comb begin
    bus.BusB  = r_regs[bus.RB];
    bus.BusyB = r_busy[bus.RB];
    if (w_fwd_b) begin
      bus.BusB = bus.BusW;
      if (!w_rersv_b) begin
        bus.BusyB = 1'b0;
      end
    end
    if (is_zero(bus.RB) || !Reset_n) begin
      bus.BusB  = '0;
      bus.BusyB = 1'b0;
    end
  end

  assign bus.AnyBusy = Reset_n && (|r_busy);
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter WIDTH, default 64, data width of every register and bus in bits.
REQ-002 Parameter DEPTH, default 32, number of architectural registers; SHALL be a power of two, at least 2.
REQ-003 Parameter ZERO_REG, default DEPTH-1, index hardwired to zero; a value of DEPTH or greater disables the zero register.
REQ-004 Parameter BYPASS, default 1, enables write-to-read forwarding when 1.
REQ-005 Derived width AW = log2(DEPTH) SHALL size all register-index ports.
REQ-006 Clk  input  1  single clock; all state updates on the rising edge.
REQ-007 Reset_n  input  1  asynchronous, active-low reset.
REQ-008 RA  input  AW  read-port A register index.
REQ-009 RB  input  AW  read-port B register index.
REQ-010 BusA  output  WIDTH  read-port A data.
REQ-011 BusB  output  WIDTH  read-port B data.
REQ-012 BusyA  output  1  register RA has an outstanding reservation.
REQ-013 BusyB  output  1  register RB has an outstanding reservation.
REQ-014 RW  input  AW  write-back register index.
REQ-015 BusW  input  WIDTH  write-back data.
REQ-016 RegWr  input  1  write-back enable.
REQ-017 RRsv  input  AW  register index to reserve (mark pending).
REQ-018 RsvEn  input  1  reservation enable.
REQ-019 AnyBusy  output  1  at least one register is reserved.

Function
REQ-020 Reads SHALL be combinational from RA/RB to BusA/BusB and BusyA/BusyB, with no clock latency.
REQ-021 A read of ZERO_REG (when enabled) SHALL return 0 and Busy 0, regardless of stored state or bypass.
REQ-022 With RegWr=1, RW not equal to ZERO_REG, and RW equal to RA, BusA SHALL equal BusW in the same cycle when BYPASS=1; port B behaves identically.
REQ-023 With BYPASS=0, a read of the register being written SHALL return the old value until the rising edge.
REQ-024 On a rising edge with RegWr=1 and RW not equal to ZERO_REG, registers[RW] SHALL take BusW; writes to ZERO_REG SHALL be discarded.
REQ-025 Each register SHALL have one busy bit; a rising edge with RsvEn=1 and RRsv not equal to ZERO_REG SHALL set busy[RRsv].
REQ-026 A rising edge with RegWr=1 SHALL clear busy[RW] unless REQ-027 applies.
REQ-027 When RsvEn and RegWr target the same register in one cycle, the reservation SHALL win: the data is written and busy stays 1, for a new producer.
REQ-028 Reservations of ZERO_REG SHALL be ignored; busy[ZERO_REG] SHALL read 0 at all times.
REQ-029 BusyA/BusyB SHALL reflect the registered busy bit; when BYPASS=1 and a same-cycle write-back to RA/RB is not also being re-reserved, BusyA/BusyB SHALL read 0 in that cycle.
REQ-030 AnyBusy SHALL be the OR of all busy bits (registered state only, no bypass).
REQ-031 Reserving an already-busy register SHALL keep it busy; writing a non-busy register SHALL leave it non-busy.

Reset
REQ-032 Reset_n=0 SHALL asynchronously clear every register to 0 and every busy bit to 0, independent of Clk.
REQ-033 During reset, BusA, BusB, BusyA, BusyB and AnyBusy SHALL read 0 irrespective of RegWr/BusW/RsvEn.
REQ-034 Reset assertion mid-operation SHALL abandon any in-flight write or reservation in that cycle.
REQ-035 Deassertion SHALL take effect synchronously: the first update occurs on the first rising edge after Reset_n goes high.

Verification
REQ-036 Reset, then read all DEPTH indices on both ports -> all BusA/BusB=0 and all Busy=0; AnyBusy=0.
REQ-037 Write 0x1234 to R5 (RegWr=1, RW=5) and read RA=5 in the same cycle -> BusA=0x1234 before the edge when BYPASS=1, and 0 before / 0x1234 after the edge when BYPASS=0.
REQ-038 Write 0xFFFF_FFFF_FFFF_FFFF to RW=31 (default params), then read RA=RB=31 -> BusA=BusB=0; RsvEn with RRsv=31 -> BusyA=0 and AnyBusy=0.
REQ-039 Reserve R3, then two idle cycles, then write R3=0xAB -> BusyA (RA=3)=1 during the idle cycles and 0 after the write edge; AnyBusy follows the same pattern.
REQ-040 Reserve R7 and write R7=0x55 in the same cycle -> after the edge registers[7]=0x55 and BusyA (RA=7)=1.
REQ-041 Write R1=0x99 with R2 reserved, then pulse Reset_n low between clock edges -> BusA/BusyB drop to 0 immediately; after release, R1 reads 0 and AnyBusy=0.
